// File: rtl/ff_bank_pkg.sv
// Shared types and constants for the ff_bank configurable flip-flop bank.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  // Responses to S=1/R=1; any other encoding falls back to hold.
  localparam logic [1:0] SR_HOLD    = 2'd0;
  localparam logic [1:0] SR_SET_DOM = 2'd1;
  localparam logic [1:0] SR_RST_DOM = 2'd2;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] sum;
    sum = '0;
    for (int i = 0; i < 32; i++) sum = sum + 6'(v[i]);
    return sum;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One storage channel: a D/T/JK/SR flip-flop selected per cycle by mode,
// with a strobe flagging the S=1/R=1 combination.
module ff_cell
  import ff_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  mode_e      mode,
  input  logic       a,
  input  logic       b,
  input  logic       rst_val,
  input  logic [1:0] policy,
  output logic       q,
  output logic       invalid
);

  logic q_next;

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    q_next  = q;
    invalid = 1'b0;
    if (en) begin
      case (mode)
        MODE_D:  q_next = a;
        MODE_T:  q_next = q ^ a;
        MODE_JK: begin
          case ({a, b})
            2'b00: q_next = q;
            2'b01: q_next = 1'b0;
            2'b10: q_next = 1'b1;
            2'b11: q_next = ~q;
          endcase
        end
        MODE_SR: begin
          case ({a, b})
            2'b00: q_next = q;
            2'b01: q_next = 1'b0;
            2'b10: q_next = 1'b1;
            2'b11: begin
              invalid = 1'b1;
              case (policy)
                SR_SET_DOM: q_next = 1'b1;
                SR_RST_DOM: q_next = 1'b0;
                default:    q_next = q;
              endcase
            end
          endcase
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so all cells update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) q <= rst_val;
    else     q <= q_next;
  end

endmodule

// File: rtl/ff_bank.sv
// Bank of N run-time configurable flip-flops with sticky error flags and irq.
// Define FF_BANK_ERR_CNT_EN to add the saturating invalid-event counter.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int             N         = 8,
  parameter logic [N-1:0]   RST_VAL   = '0,
  parameter int             SR_POLICY = 0,
  parameter int             CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     en,
  input  logic [2*N-1:0]   mode,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [N-1:0]     q,
  output logic [N-1:0]     err,
  input  logic [N-1:0]     err_clr,
  output logic             irq
`ifdef FF_BANK_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
`endif
);

  localparam logic [1:0] POLICY = 2'(SR_POLICY);

  logic [N-1:0] invalid;

  for (genvar i = 0; i < N; i++) begin : g_cell
    ff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .mode    (mode_e'(mode[2*i +: 2])),
      .a       (a[i]),
      .b       (b[i]),
      .rst_val (RST_VAL[i]),
      .policy  (POLICY),
      .q       (q[i]),
      .invalid (invalid[i])
    );
  end

  // A new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) err <= '0;
    else     err <= (err & ~err_clr) | invalid;
  end

  assign irq = |err;

`ifdef FF_BANK_ERR_CNT_EN
  localparam int              SUM_W   = CNT_W + 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [5:0]       pop;
  logic [SUM_W-1:0] sum;

  always_comb begin
    pop = popcount(32'(invalid));
    sum = (cnt_clr ? '0 : SUM_W'(err_cnt)) + SUM_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst)                         err_cnt <= '0;
    else if (sum > SUM_W'(CNT_MAX))  err_cnt <= CNT_MAX;
    else                             err_cnt <= sum[CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_ff_bank.sv
// Scoreboard bench for ff_bank: three instances differ only in SR_POLICY.
module tb_ff_bank;
  import ff_bank_pkg::*;

  localparam int N = 8;
  localparam int CNT_W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   en, a, b, err_clr;
  logic [2*N-1:0] mode;
  logic           cnt_clr;
  logic [N-1:0]   q0, q1, q2, err0, err1, err2;
  logic           irq0, irq1, irq2;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2;

  always #5 clk = ~clk;

  ff_bank #(.N(N), .RST_VAL(8'hA5), .SR_POLICY(0), .CNT_W(CNT_W)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .q(q0),
    .err(err0), .err_clr(err_clr), .irq(irq0)
`ifdef FF_BANK_ERR_CNT_EN
    , .err_cnt(cnt0), .cnt_clr(cnt_clr)
`endif
  );
  ff_bank #(.N(N), .RST_VAL(8'hA5), .SR_POLICY(1), .CNT_W(CNT_W)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .q(q1),
    .err(err1), .err_clr(err_clr), .irq(irq1)
`ifdef FF_BANK_ERR_CNT_EN
    , .err_cnt(cnt1), .cnt_clr(cnt_clr)
`endif
  );
  ff_bank #(.N(N), .RST_VAL(8'hA5), .SR_POLICY(2), .CNT_W(CNT_W)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .q(q2),
    .err(err2), .err_clr(err_clr), .irq(irq2)
`ifdef FF_BANK_ERR_CNT_EN
    , .err_cnt(cnt2), .cnt_clr(cnt_clr)
`endif
  );

`ifndef FF_BANK_ERR_CNT_EN
  assign cnt0 = '0;
  assign cnt1 = '0;
  assign cnt2 = '0;
`endif

  typedef struct {
    string            name;
    logic [N-1:0]     q0, q1, q2, err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [2*N-1:0] rep(input mode_e m);
    return {N{m}};
  endfunction

  // Drive one cycle of stimulus and queue what the outputs must show after the edge.
  task automatic step(input string nm, input logic r, input logic [N-1:0] e,
                      input mode_e m, input logic [N-1:0] va, input logic [N-1:0] vb,
                      input logic [N-1:0] clr, input logic cc,
                      input logic [N-1:0] x0, input logic [N-1:0] x1, input logic [N-1:0] x2,
                      input logic [N-1:0] xe, input logic [CNT_W-1:0] xc);
    exp_t ex;
    @(negedge clk);
    rst = r; en = e; mode = rep(m); a = va; b = vb; err_clr = clr; cnt_clr = cc;
    ex.name = nm; ex.q0 = x0; ex.q1 = x1; ex.q2 = x2; ex.err = xe; ex.cnt = xc;
    sb.push_back(ex);
    @(posedge clk);
  endtask

  // Monitor: outputs are presented every cycle, compared 1 time unit after the edge.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        check({ex.name, " q0"},  32'(q0),   32'(ex.q0));
        check({ex.name, " q1"},  32'(q1),   32'(ex.q1));
        check({ex.name, " q2"},  32'(q2),   32'(ex.q2));
        check({ex.name, " err"}, 32'(err0), 32'(ex.err));
        check({ex.name, " err_p"}, 32'(err1 | err2), 32'(ex.err));
        check({ex.name, " irq"}, 32'(irq0), 32'(ex.err != '0));
`ifdef FF_BANK_ERR_CNT_EN
        check({ex.name, " cnt"}, 32'(cnt0), 32'(ex.cnt));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; en = '0; mode = '0; a = '0; b = '0; err_clr = '0; cnt_clr = 1'b0;
    // Reset with arbitrary inputs, then with inputs that would otherwise raise errors.
    step("rst_rand", 1'b1, 8'($urandom()), mode_e'(2'($urandom())), 8'($urandom()),
         8'($urandom()), 8'($urandom()), 1'($urandom()), 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    step("rst_sr11", 1, 8'hFF, MODE_SR, 8'hFF, 8'hFF, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    // D mode
    step("d_0a",  0, 8'h01, MODE_D,  8'h00, 8'h00, 8'h00, 0, 8'hA4, 8'hA4, 8'hA4, 8'h00, 4'd0);
    step("d_1",   0, 8'h01, MODE_D,  8'h01, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    step("d_0b",  0, 8'h01, MODE_D,  8'h00, 8'h00, 8'h00, 0, 8'hA4, 8'hA4, 8'hA4, 8'h00, 4'd0);
    // T mode from q=0
    step("t_1",   0, 8'h01, MODE_T,  8'h01, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    step("t_2",   0, 8'h01, MODE_T,  8'h01, 8'h00, 8'h00, 0, 8'hA4, 8'hA4, 8'hA4, 8'h00, 4'd0);
    step("t_3",   0, 8'h01, MODE_T,  8'h01, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    step("t_hold",0, 8'h01, MODE_T,  8'h00, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    // JK mode
    step("jk_01", 0, 8'h01, MODE_JK, 8'h00, 8'h01, 8'h00, 0, 8'hA4, 8'hA4, 8'hA4, 8'h00, 4'd0);
    step("jk_11a",0, 8'h01, MODE_JK, 8'h01, 8'h01, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    step("jk_11b",0, 8'h01, MODE_JK, 8'h01, 8'h01, 8'h00, 0, 8'hA4, 8'hA4, 8'hA4, 8'h00, 4'd0);
    step("jk_10", 0, 8'h01, MODE_JK, 8'h01, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    step("jk_00", 0, 8'h01, MODE_JK, 8'h00, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    // SR mode and the 1/1 policies from q=1, then from q=0
    step("sr_01", 0, 8'h01, MODE_SR, 8'h00, 8'h01, 8'h00, 0, 8'hA4, 8'hA4, 8'hA4, 8'h00, 4'd0);
    step("sr_10", 0, 8'h01, MODE_SR, 8'h01, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    step("sr_00", 0, 8'h01, MODE_SR, 8'h00, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    step("sr_11q1",0,8'h01, MODE_SR, 8'h01, 8'h01, 8'h00, 0, 8'hA5, 8'hA5, 8'hA4, 8'h01, 4'd1);
    step("sr_clr",0, 8'h01, MODE_SR, 8'h00, 8'h01, 8'h01, 0, 8'hA4, 8'hA4, 8'hA4, 8'h00, 4'd1);
    step("sr_11q0",0,8'h01, MODE_SR, 8'h01, 8'h01, 8'h00, 0, 8'hA4, 8'hA5, 8'hA4, 8'h01, 4'd2);
    // Disabled channels hold and raise nothing
    step("dis_clr",0,8'h00, MODE_SR, 8'hFF, 8'hFF, 8'h01, 0, 8'hA4, 8'hA5, 8'hA4, 8'h00, 4'd2);
    step("dis_11",0, 8'h00, MODE_SR, 8'hFF, 8'hFF, 8'h00, 0, 8'hA4, 8'hA5, 8'hA4, 8'h00, 4'd2);
    // Mode switch JK -> D on channel 2 with q=1
    step("sw_jk", 0, 8'h04, MODE_JK, 8'h00, 8'h00, 8'h00, 0, 8'hA4, 8'hA5, 8'hA4, 8'h00, 4'd2);
    step("sw_d",  0, 8'h04, MODE_D,  8'h00, 8'h00, 8'h00, 0, 8'hA0, 8'hA1, 8'hA0, 8'h00, 4'd2);
    // err_clr racing a new event on channel 3
    step("race_set",0,8'h08,MODE_SR, 8'h08, 8'h08, 8'h00, 0, 8'hA0, 8'hA9, 8'hA0, 8'h08, 4'd3);
    step("race_clr",0,8'h08,MODE_SR, 8'h08, 8'h08, 8'h08, 0, 8'hA0, 8'hA9, 8'hA0, 8'h08, 4'd4);
    step("clr_only",0,8'h00,MODE_SR, 8'h00, 8'h00, 8'h08, 1, 8'hA0, 8'hA9, 8'hA0, 8'h00, 4'd0);
    // Five events per cycle: counter saturates at 15
    step("cnt_5", 0, 8'h1F, MODE_SR, 8'h1F, 8'h1F, 8'h00, 0, 8'hA0, 8'hBF, 8'hA0, 8'h1F, 4'd5);
    step("cnt_10",0, 8'h1F, MODE_SR, 8'h1F, 8'h1F, 8'h00, 0, 8'hA0, 8'hBF, 8'hA0, 8'h1F, 4'd10);
    step("cnt_15",0, 8'h1F, MODE_SR, 8'h1F, 8'h1F, 8'h00, 0, 8'hA0, 8'hBF, 8'hA0, 8'h1F, 4'd15);
    step("cnt_sat",0,8'h1F, MODE_SR, 8'h1F, 8'h1F, 8'h00, 0, 8'hA0, 8'hBF, 8'hA0, 8'h1F, 4'd15);
    step("cnt_ld",0, 8'h03, MODE_SR, 8'h03, 8'h03, 8'h00, 1, 8'hA0, 8'hBF, 8'hA0, 8'h1F, 4'd2);
    // Mid-sequence reset, then resume
    step("rst_mid",1, 8'hFF, MODE_SR, 8'hFF, 8'hFF, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 4'd0);
    step("resume",0, 8'h01, MODE_D,  8'h00, 8'h00, 8'h00, 0, 8'hA4, 8'hA4, 8'hA4, 8'h00, 4'd0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised bank of N independent single-bit storage cells. Each cell is configurable at run time as a D, T, JK or SR flip-flop, with a per-channel clock enable, a defined policy for the SR 1/1 input combination, sticky invalid-input flags and an interrupt. It is the general-purpose successor to the team's single SR flip-flop. It sits wherever control or status bits must be held and updated under software-selected semantics.

## Interface
Parameters:
- N, 8, number of channels (1..32)
- RST_VAL, N'b0, per-channel reset value of q
- SR_POLICY, 0, response to SR 1/1: 0 = hold, 1 = set-dominant, 2 = reset-dominant
- CNT_W, 8, width of the invalid-event counter (only used with FF_BANK_ERR_CNT_EN)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- en  in  N  per-channel enable; 0 = the channel holds q
- mode  in  2*N  per-channel mode, channel i at bits [2i+1:2i]; 00 D, 01 T, 10 JK, 11 SR
- a  in  N  D / T / J / S input per channel
- b  in  N  K / R input per channel; ignored in D and T modes
- q  out  N  cell outputs
- err  out  N  sticky invalid-input flag per channel
- err_clr  in  N  write-1-to-clear for err
- irq  out  1  OR-reduction of err
- err_cnt  out  CNT_W  saturating invalid-event count (macro only)
- cnt_clr  in  1  clears err_cnt (macro only)

## Operation
- Reset: q = RST_VAL, err = 0, err_cnt = 0, irq = 0. rst overrides en, err_clr and all data inputs.
- When en[i] = 0, q[i] holds. Mode and inputs for that channel are ignored, and no error is raised.
- When en[i] = 1, mode is sampled on the same edge that applies it. There is no mode-change latency and q is not reset on a mode change.
- D mode: q ← a.
- T mode: q ← q ^ a.
- JK mode: 00 hold, 01 clear, 10 set, 11 toggle.
- SR mode: 00 hold, 01 clear, 10 set.
- SR mode, 11: q follows SR_POLICY (hold / 1 / 0), and the combination counts as an invalid event. q never goes to X.
- An invalid event on channel i sets err[i] on that edge.
- err_clr[i] clears err[i]. If a new invalid event occurs in the same cycle, set wins.
- irq is the combinational OR of the err registers.

## Timing
- q, err and err_cnt are registered. Each reflects inputs sampled at edge k from edge k onward, i.e. one cycle of latency from input to output.
- irq has the same timing as err; no extra register stage.
- If rst is asserted mid-sequence, every register returns to its reset value on the next edge. Operation resumes on the first edge after rst deasserts.
- The valid SR_POLICY values are 0..2. A value of 3 behaves as 0 (hold).

## Configuration
- FF_BANK_ERR_CNT_EN defined:
  - err_cnt and cnt_clr exist.
  - Each cycle, err_cnt adds the popcount of that cycle's invalid events and saturates at 2^CNT_W-1.
  - If cnt_clr is asserted together with events, err_cnt loads that cycle's popcount.
  - Events are counted even when err is already set.
- FF_BANK_ERR_CNT_EN undefined: the err_cnt and cnt_clr ports and the counter logic are absent. All other behaviour is identical.

## Structure
- Package ff_bank_pkg holds:
  - the mode enum (MODE_D, MODE_T, MODE_JK, MODE_SR)
  - the SR policy constants (SR_HOLD, SR_SET_DOM, SR_RST_DOM)
- Sub-module ff_cell implements one channel. Inputs: en, mode, a, b, q_reset value, policy. Outputs: q and an invalid strobe.
- The top level instantiates N ff_cell channels plus the err flags, the irq OR and the optional popcount/saturating counter.

## Test plan
- Reset: rst = 1 with RST_VAL = 8'hA5 and random inputs -> q = 8'hA5, err = 0, irq = 0, err_cnt = 0 the edge after rst.
- Per-mode truth tables on channel 0 (en = 1), checked each cycle:
  - D: a = 1 -> q = 1.
  - T from q = 0: a = 1 for 3 cycles -> q = 1, 0, 1.
  - JK from q = 0: 11 for 2 cycles -> q = 1, 0.
  - SR: 10 -> q = 1; 01 -> q = 0.
- SR 1/1 policy:
  - SR_POLICY = 0, q = 1 -> q stays 1.
  - SR_POLICY = 1 -> q = 1.
  - SR_POLICY = 2 -> q = 0.
  - All three: err[0] = 1 and irq = 1 on the same edge.
- Enable and mode switch:
  - en = 0 with SR 11 -> q holds, err stays 0.
  - Switch a channel from JK to D with q = 1, a = 0 -> q = 0 after one edge, no intermediate reset.
- err clear race: err[3] = 1, then err_clr[3] = 1 with SR 11 on channel 3 in the same cycle -> err[3] remains 1. err_clr alone next cycle -> err[3] = 0, irq = 0.
- Counter (macro on, CNT_W = 4):
  - 5 channels in SR 11 per cycle for 4 cycles -> err_cnt = 5, 10, 15, 15 (saturates).
  - cnt_clr together with 2 events -> err_cnt = 2.
